// File: rtl/pvt_ts_sequencer.sv
// pvt_ts_sequencer
// Temperature/voltage path controller for a PVT sensor macro. Powers the
// macro up, waits a settle time, then round-robins over the enabled channels:
// for each one it drives that channel's select code, holds start-of-conversion
// for a fixed number of cycles, waits for end-of-conversion with a timeout,
// and streams the captured code out with its channel index. It also keeps
// sticky per-channel high/low threshold alarms and a sticky timeout flag.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_enable            run the sequencer
//   i_ch_mask           per-channel enable bits
//   i_ch_sel            per-channel select code, ch0 in the LSBs
//   i_thresh_hi/lo      alarm thresholds (strict compare)
//   i_alarm_clr         one-cycle clear of alarms and timeout flag
//   o_en_ts/o_soc_ts/o_sel_ts   macro enable / start / input select
//   i_eoc_ts/i_out_ts   macro end-of-conversion (synchronised) and result
//   o_result_valid/ch/data      one-cycle result strobe, channel, code
//   o_alarm_hi/lo       sticky threshold alarms per channel
//   o_timeout_err       sticky EOC timeout flag
//   o_busy              sequencer not idle
module pvt_ts_sequencer #(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 12,
    parameter int SEL_W        = 4,
    parameter int SETTLE_CYC   = 16,
    parameter int SOC_HOLD_CYC = 8,
    parameter int TIMEOUT_CYC  = 4096,
    parameter int CH_IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic [NUM_CH-1:0]       i_ch_mask,
    input  logic [NUM_CH*SEL_W-1:0] i_ch_sel,
    input  logic [DATA_W-1:0]       i_thresh_hi,
    input  logic [DATA_W-1:0]       i_thresh_lo,
    input  logic                    i_alarm_clr,
    output logic                    o_en_ts,
    output logic                    o_soc_ts,
    output logic [SEL_W-1:0]        o_sel_ts,
    input  logic                    i_eoc_ts,
    input  logic [DATA_W-1:0]       i_out_ts,
    output logic                    o_result_valid,
    output logic [CH_IDX_W-1:0]     o_result_ch,
    output logic [DATA_W-1:0]       o_result_data,
    output logic [NUM_CH-1:0]       o_alarm_hi,
    output logic [NUM_CH-1:0]       o_alarm_lo,
    output logic                    o_timeout_err,
    output logic                    o_busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_SOC     = 3'd2;
    localparam logic [2:0] S_WAITEOC = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;

    localparam int CNT_MAX0 = (SETTLE_CYC > SOC_HOLD_CYC) ? SETTLE_CYC : SOC_HOLD_CYC;
    localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT_CYC) ? CNT_MAX0 : TIMEOUT_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    logic [2:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CH_IDX_W-1:0] r_ch;
    logic [CH_IDX_W-1:0] r_ptr;
    logic                r_eoc_q;

    logic [2:0]          w_state_nxt;
    logic [CH_IDX_W-1:0] w_ch_inc;
    logic [CH_IDX_W-1:0] w_start;
    logic                w_found;
    logic [CH_IDX_W-1:0] w_found_ch;
    logic [SEL_W-1:0]    w_sel;
    logic                w_eoc_rise;
    logic                w_cnt_last;
    logic [NUM_CH-1:0]   w_ch_onehot;
    logic [NUM_CH-1:0]   w_hi_set;
    logic [NUM_CH-1:0]   w_lo_set;
    logic                w_to_set;

    assign w_ch_inc    = (r_ch == CH_IDX_W'(NUM_CH - 1)) ? '0 : r_ch + CH_IDX_W'(1);
    // SETTLE searches from the stored pointer; NEXT searches from the channel
    // after the one just converted, which is also what the pointer becomes.
    assign w_start     = (r_state == S_NEXT) ? w_ch_inc : r_ptr;
    assign w_sel       = i_ch_sel[w_found_ch*SEL_W +: SEL_W];
    // Edge only: a level already high before WAIT_EOC leaves r_eoc_q set.
    assign w_eoc_rise  = i_eoc_ts & ~r_eoc_q;
    assign w_cnt_last  = (r_cnt <= CNT_W'(1));
    assign w_ch_onehot = NUM_CH'(1) << r_ch;

    // First enabled channel at or after w_start, wrapping.
    always_comb begin
        w_found    = 1'b0;
        w_found_ch = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && i_ch_mask[(int'(w_start) + i) % NUM_CH]) begin
                w_found    = 1'b1;
                w_found_ch = CH_IDX_W'((int'(w_start) + i) % NUM_CH);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_enable && (|i_ch_mask)) w_state_nxt = S_SETTLE;
            S_SETTLE:  if (w_cnt_last) w_state_nxt = w_found ? S_SOC : S_IDLE;
            S_SOC:     if (w_cnt_last) w_state_nxt = S_WAITEOC;
            S_WAITEOC: begin
                if (w_eoc_rise)      w_state_nxt = S_CAPTURE;
                else if (w_cnt_last) w_state_nxt = S_NEXT;
            end
            S_CAPTURE: w_state_nxt = S_NEXT;
            S_NEXT:    w_state_nxt = (!i_enable || !w_found) ? S_IDLE : S_SOC;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // The captured code is already in o_result_data during CAPTURE.
    always_comb begin
        w_hi_set = '0;
        w_lo_set = '0;
        if (r_state == S_CAPTURE) begin
            if (o_result_data > i_thresh_hi) w_hi_set = w_ch_onehot;
            if (o_result_data < i_thresh_lo) w_lo_set = w_ch_onehot;
        end
    end

    assign w_to_set = (r_state == S_WAITEOC) && (w_state_nxt == S_NEXT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_ch           <= '0;
            r_ptr          <= '0;
            r_eoc_q        <= 1'b0;
            o_en_ts        <= 1'b0;
            o_soc_ts       <= 1'b0;
            o_sel_ts       <= '0;
            o_result_valid <= 1'b0;
            o_result_ch    <= '0;
            o_result_data  <= '0;
            o_alarm_hi     <= '0;
            o_alarm_lo     <= '0;
            o_timeout_err  <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            o_busy         <= (w_state_nxt != S_IDLE);
            r_eoc_q        <= i_eoc_ts;
            o_result_valid <= 1'b0;

            // Set wins over a coincident clear.
            o_alarm_hi    <= (o_alarm_hi & ~{NUM_CH{i_alarm_clr}}) | w_hi_set;
            o_alarm_lo    <= (o_alarm_lo & ~{NUM_CH{i_alarm_clr}}) | w_lo_set;
            o_timeout_err <= (o_timeout_err & ~i_alarm_clr) | w_to_set;

            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt == S_SETTLE) begin
                        o_en_ts <= 1'b1;
                        r_cnt   <= CNT_W'(SETTLE_CYC);
                    end
                end
                S_SETTLE, S_NEXT: begin
                    if (r_state == S_NEXT) r_ptr <= w_ch_inc;
                    if (w_state_nxt == S_SOC) begin
                        r_ch     <= w_found_ch;
                        o_sel_ts <= w_sel;
                        o_soc_ts <= 1'b1;
                        r_cnt    <= CNT_W'(SOC_HOLD_CYC);
                    end else if (w_state_nxt == S_IDLE) begin
                        o_en_ts <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_SOC: begin
                    if (w_state_nxt == S_WAITEOC) begin
                        o_soc_ts <= 1'b0;
                        r_cnt    <= CNT_W'(TIMEOUT_CYC);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_WAITEOC: begin
                    if (w_state_nxt == S_CAPTURE) begin
                        o_result_valid <= 1'b1;
                        o_result_data  <= i_out_ts;
                        o_result_ch    <= r_ch;
                    end else if (w_state_nxt == S_WAITEOC) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pvt_ts_sequencer.sv
module tb_pvt_ts_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  ch_mask;
    logic [15:0] ch_sel;
    logic [11:0] thresh_hi, thresh_lo;
    logic        alarm_clr;
    logic        en_ts, soc_ts;
    logic [3:0]  sel_ts;
    logic        eoc_ts;
    logic [11:0] out_ts;
    logic        res_valid;
    logic [1:0]  res_ch;
    logic [11:0] res_data;
    logic [3:0]  alarm_hi, alarm_lo;
    logic        timeout_err, busy;

    int n_tests = 0;
    int n_fail  = 0;

    pvt_ts_sequencer #(
        .NUM_CH(4), .DATA_W(12), .SEL_W(4),
        .SETTLE_CYC(16), .SOC_HOLD_CYC(8), .TIMEOUT_CYC(64)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_ch_mask(ch_mask),
        .i_ch_sel(ch_sel), .i_thresh_hi(thresh_hi), .i_thresh_lo(thresh_lo),
        .i_alarm_clr(alarm_clr), .o_en_ts(en_ts), .o_soc_ts(soc_ts),
        .o_sel_ts(sel_ts), .i_eoc_ts(eoc_ts), .i_out_ts(out_ts),
        .o_result_valid(res_valid), .o_result_ch(res_ch),
        .o_result_data(res_data), .o_alarm_hi(alarm_hi), .o_alarm_lo(alarm_lo),
        .o_timeout_err(timeout_err), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_soc(input logic lvl, input string tag);
        int k = 0;
        while (soc_ts !== lvl && k < 100) begin
            tick(1);
            k++;
        end
        chk(tag, {31'd0, soc_ts}, {31'd0, lvl});
    endtask

    // One full conversion: expect SOC with the given select, then pulse EOC.
    task automatic conv(input logic [1:0] ch, input logic [11:0] data);
        wait_soc(1'b1, "soc_rise");
        chk("sel", {28'd0, sel_ts}, {30'd0, ch});
        wait_soc(1'b0, "soc_fall");
        out_ts = data;
        eoc_ts = 1'b1;
        tick(1);
        chk("valid", {31'd0, res_valid}, 32'd1);
        chk("res_ch", {30'd0, res_ch}, {30'd0, ch});
        chk("res_data", {20'd0, res_data}, {20'd0, data});
        eoc_ts = 1'b0;
    endtask

    initial begin
        logic seen;
        rst = 1'b1; enable = 1'b0; ch_mask = 4'b0; ch_sel = 16'h3210;
        thresh_hi = 12'hFFF; thresh_lo = 12'h000; alarm_clr = 1'b0;
        eoc_ts = 1'b0; out_ts = 12'h000;
        tick(2);
        chk("rst_en", {31'd0, en_ts}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_soc", {31'd0, soc_ts}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_alarms", {24'd0, alarm_hi, alarm_lo}, 32'd0);
        rst = 1'b0;

        // 1: power-up timing and full round robin
        ch_mask = 4'b1111; enable = 1'b1;
        tick(1);
        chk("en_rise", {31'd0, en_ts}, 32'd1);
        chk("busy", {31'd0, busy}, 32'd1);
        tick(15);
        chk("soc_early", {31'd0, soc_ts}, 32'd0);
        tick(1);
        chk("soc_at16", {31'd0, soc_ts}, 32'd1);
        chk("sel0", {28'd0, sel_ts}, 32'd0);
        tick(7);
        chk("soc_hold7", {31'd0, soc_ts}, 32'd1);
        tick(1);
        chk("soc_drop8", {31'd0, soc_ts}, 32'd0);
        out_ts = 12'h5A5; eoc_ts = 1'b1;
        tick(1);
        chk("valid0", {31'd0, res_valid}, 32'd1);
        chk("ch0", {30'd0, res_ch}, 32'd0);
        chk("data0", {20'd0, res_data}, 32'h5A5);
        eoc_ts = 1'b0;
        tick(1);
        chk("valid_1cyc", {31'd0, res_valid}, 32'd0);
        chk("data_hold", {20'd0, res_data}, 32'h5A5);
        conv(2'd1, 12'h111);
        conv(2'd2, 12'h222);
        conv(2'd3, 12'h333);
        conv(2'd0, 12'h444);

        // 2: sparse mask, ch0/ch2 skipped
        ch_mask = 4'b1010;
        conv(2'd1, 12'h011);
        conv(2'd3, 12'h033);
        conv(2'd1, 12'h011);
        conv(2'd3, 12'h033);

        // 3: threshold alarms, equality, clear, set-beats-clear
        thresh_hi = 12'h800; thresh_lo = 12'h100; ch_mask = 4'b1110;
        conv(2'd1, 12'h801);
        conv(2'd2, 12'h800);
        conv(2'd3, 12'h0FF);
        tick(1);
        chk("alarm_hi", {28'd0, alarm_hi}, 32'b0010);
        chk("alarm_lo", {28'd0, alarm_lo}, 32'b1000);
        alarm_clr = 1'b1;
        tick(1);
        alarm_clr = 1'b0;
        chk("clr_hi", {28'd0, alarm_hi}, 32'd0);
        chk("clr_lo", {28'd0, alarm_lo}, 32'd0);
        conv(2'd1, 12'h900);
        alarm_clr = 1'b1;
        tick(1);
        alarm_clr = 1'b0;
        chk("set_wins_hi", {28'd0, alarm_hi}, 32'b0010);
        chk("set_wins_lo", {28'd0, alarm_lo}, 32'd0);

        // 4: EOC timeout on ch0
        ch_mask = 4'b0011; thresh_hi = 12'hFFF; thresh_lo = 12'h000;
        wait_soc(1'b1, "to_soc");
        chk("to_sel", {28'd0, sel_ts}, 32'd0);
        wait_soc(1'b0, "to_wait");
        seen = 1'b0;
        for (int i = 0; i < 63; i++) begin
            tick(1);
            if (res_valid) seen = 1'b1;
        end
        chk("to_early", {31'd0, timeout_err}, 32'd0);
        chk("to_nostrobe", {31'd0, seen}, 32'd0);
        tick(1);
        chk("to_at64", {31'd0, timeout_err}, 32'd1);
        chk("to_nostrobe2", {31'd0, res_valid}, 32'd0);
        tick(1);
        tick(1);
        chk("to_next_soc", {31'd0, soc_ts}, 32'd1);
        conv(2'd1, 12'h400);

        // 6: EOC already high on WAIT_EOC entry
        wait_soc(1'b1, "lvl_soc");
        chk("lvl_sel", {28'd0, sel_ts}, 32'd0);
        out_ts = 12'h777; eoc_ts = 1'b1;
        wait_soc(1'b0, "lvl_wait");
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (res_valid) seen = 1'b1;
        end
        eoc_ts = 1'b0;
        tick(1);
        if (res_valid) seen = 1'b1;
        chk("lvl_nocap", {31'd0, seen}, 32'd0);
        out_ts = 12'h123; eoc_ts = 1'b1;
        tick(1);
        chk("lvl_valid", {31'd0, res_valid}, 32'd1);
        chk("lvl_data", {20'd0, res_data}, 32'h123);
        chk("lvl_ch", {30'd0, res_ch}, 32'd0);
        eoc_ts = 1'b0;

        // 5: drop enable mid-WAIT_EOC, then reset mid-SOC
        wait_soc(1'b1, "dis_soc");
        chk("dis_sel", {28'd0, sel_ts}, 32'd1);
        wait_soc(1'b0, "dis_wait");
        enable = 1'b0;
        tick(2);
        out_ts = 12'h2AB; eoc_ts = 1'b1;
        tick(1);
        chk("dis_valid", {31'd0, res_valid}, 32'd1);
        chk("dis_data", {20'd0, res_data}, 32'h2AB);
        eoc_ts = 1'b0;
        tick(2);
        chk("dis_en", {31'd0, en_ts}, 32'd0);
        chk("dis_busy", {31'd0, busy}, 32'd0);
        alarm_clr = 1'b1;
        tick(1);
        alarm_clr = 1'b0;
        chk("clr_to", {31'd0, timeout_err}, 32'd0);

        enable = 1'b1;
        wait_soc(1'b1, "rst_soc_rise");
        chk("rst_soc_sel", {28'd0, sel_ts}, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_soc", {31'd0, soc_ts}, 32'd0);
        chk("mid_rst_en", {31'd0, en_ts}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        enable = 1'b0;
        tick(2);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pvt_ts_sequencer.md
Name: pvt_ts_sequencer

Overview:
- Parametrised controller for the temperature/voltage path of a PVT sensor macro.
- Powers up the macro, round-robins over up to NUM_CH enabled sensing channels (one SEL_TS code each), and pulses start-of-conversion.
- Waits for end-of-conversion with a timeout, captures the 12-bit result and streams it out with its channel index.
- Keeps sticky per-channel high/low threshold alarms. Sits between the SoC PVT CSR block and the sensor macro.

Parameters:
NUM_CH, 4, number of sequenced channels (1..16)
DATA_W, 12, sensor output code width
SEL_W, 4, per-channel sensor select code width
SETTLE_CYC, 16, i_clk cycles between o_en_ts rise and first SOC (>=1)
SOC_HOLD_CYC, 8, cycles o_soc_ts is held high (>=1)
TIMEOUT_CYC, 4096, max cycles waiting for EOC (>=2)
CH_IDX_W, $clog2(NUM_CH) min 1, channel index width (derived)

Ports:
i_clk  in  1  block clock
i_rst  in  1  synchronous active-high reset
i_enable  in  1  run sequencer
i_ch_mask  in  NUM_CH  channel enable bits
i_ch_sel  in  NUM_CH*SEL_W  SEL_TS code per channel, ch0 in LSBs
i_thresh_hi  in  DATA_W  high alarm threshold
i_thresh_lo  in  DATA_W  low alarm threshold
i_alarm_clr  in  1  one-cycle clear of all alarms and timeout error
o_en_ts  out  1  macro enable
o_soc_ts  out  1  start of conversion
o_sel_ts  out  SEL_W  macro input select
i_eoc_ts  in  1  end of conversion, already synchronised to i_clk
i_out_ts  in  DATA_W  conversion result, stable while i_eoc_ts high
o_result_valid  out  1  one-cycle result strobe, no backpressure
o_result_ch  out  CH_IDX_W  channel of result
o_result_data  out  DATA_W  captured result
o_alarm_hi  out  NUM_CH  sticky: result > i_thresh_hi
o_alarm_lo  out  NUM_CH  sticky: result < i_thresh_lo
o_timeout_err  out  1  sticky: EOC timeout seen
o_busy  out  1  FSM not in IDLE

Behaviour:
- All registers reset to 0: outputs 0, FSM IDLE, channel pointer 0, EOC edge-detect register 0. Reset mid-conversion drops o_en_ts and o_soc_ts on the next edge and discards the conversion.
- All outputs are registered.
- FSM states: IDLE, SETTLE, SOC, WAIT_EOC, CAPTURE, NEXT.
- IDLE:
  - o_en_ts=0.
  - If i_enable=1 and |i_ch_mask: go to SETTLE, set o_en_ts=1, load the counter with SETTLE_CYC.
- SETTLE:
  - Counter decrements each cycle.
  - At 0: pick the first enabled channel at or after the pointer (wrapping), go to SOC.
  - If the mask is 0 at that point, go to IDLE.
- SOC:
  - On entry, latch o_sel_ts from i_ch_sel[ch] and drive o_soc_ts=1 for exactly SOC_HOLD_CYC cycles.
  - Then o_soc_ts=0, go to WAIT_EOC, load the timer with TIMEOUT_CYC.
  - o_sel_ts holds through WAIT_EOC.
- WAIT_EOC:
  - Rising edge = i_eoc_ts sampled 1 with the previous sample 0. A level held high from before entry does not count.
  - On a rising edge: latch i_out_ts, go to CAPTURE.
  - If the timer reaches 0 first: set o_timeout_err, go to NEXT with no result.
  - Edge and expiry in the same cycle: the edge wins.
- CAPTURE (1 cycle):
  - o_result_valid=1 with o_result_ch/o_result_data. This is exactly 1 cycle after the edge-detect cycle.
  - Set o_alarm_hi[ch] if data > hi; set o_alarm_lo[ch] if data < lo. Equality raises no alarm.
  - Both alarms may set if hi < lo.
  - Go to NEXT.
- NEXT:
  - Advance the pointer to ch+1 modulo NUM_CH.
  - If i_enable=0 or the mask is 0: go to IDLE. o_en_ts drops on the same transition.
  - Else search round-robin for the next enabled channel and go to SOC. No re-settle while o_en_ts stays high.
  - Single enabled channel: it is reselected every round.
- i_enable and i_ch_mask are sampled only in IDLE/SETTLE/NEXT, so a conversion in progress always completes.
- i_alarm_clr clears o_alarm_hi, o_alarm_lo and o_timeout_err. A set in the same cycle wins over the clear.
- o_result_data holds its last value between strobes.

Test Plan (NUM_CH=4, SETTLE_CYC=16, SOC_HOLD_CYC=8, TIMEOUT_CYC=64, i_ch_sel={4'h3,4'h2,4'h1,4'h0}):
1. Reset, mask=4'b1111, enable=1 -> o_en_ts high 1 cycle after enable is sampled; first o_soc_ts 16 cycles later, held 8 cycles, o_sel_ts=0; EOC with data 12'h5A5 -> o_result_valid 1 cycle after edge, ch=0, data=12'h5A5; next SOC uses sel 1, then 2, 3, 0.
2. mask=4'b1010 -> channel order 1,3,1,3 (sel 1,3); ch0 and ch2 are never selected.
3. hi=12'h800, lo=12'h100; results 12'h801 on ch1, 12'h800 on ch2, 12'h0FF on ch3 -> alarm_hi=4'b0010, alarm_lo=4'b1000. Pulse i_alarm_clr -> both 0. Clear coincident with a new ch1 over-threshold result -> alarm_hi[1] stays 1.
4. No EOC on ch0 -> o_timeout_err=1 exactly 64 cycles after WAIT_EOC entry, no result strobe, sequencer moves to ch1.
5. Drop i_enable mid-WAIT_EOC -> the current result is still produced, then IDLE, o_en_ts=0, o_busy=0. Assert i_rst mid-SOC -> o_soc_ts=0 and o_en_ts=0 on the next edge, FSM IDLE.
6. i_eoc_ts already high on WAIT_EOC entry -> no capture until it goes low and then high again.
